// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the SMUL multi-cycle sequencer: opcode, FSM encodings, default width.
package alu_mul_sequencer_pkg;

    localparam int unsigned MUL_WIDTH = 16;
    localparam int unsigned OPCODE_W  = 6;

    localparam logic [OPCODE_W-1:0] SMUL = 6'h1C;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_BUSY = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    function automatic logic isSmul(input logic [OPCODE_W-1:0] opcode);
        return opcode == SMUL;
    endfunction

endpackage

// File: rtl/alu_mul_sequencer_datapath.sv
// Radix-2 shift-add datapath: operand shift registers, accumulator and iteration counter.
module mul_shift_add_datapath #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   operandA,
    input  logic [WIDTH-1:0]   operandB,
    output logic [2*WIDTH-1:0] accNext_c,
    output logic               last_c
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic [PW-1:0]    multiplicand;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] multiplier;
    logic [CNT_W-1:0] count;

    // Product of two WIDTH-bit values fits in PW bits, so this add never carries out.
    assign accNext_c = multiplier[0] ? acc + multiplicand : acc;
    assign last_c    = count == CNT_W'(WIDTH - 1);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            multiplicand <= '0;
            multiplier   <= '0;
            acc          <= '0;
            count        <= '0;
        end else if (load) begin
            multiplicand <= PW'(operandA);
            multiplier   <= operandB;
            acc          <= '0;
            count        <= '0;
        end else if (step) begin
            acc          <= accNext_c;
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            count        <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// SMUL controller: stalls the front end for WIDTH+1 cycles, then strobes the product into data RAM.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic             iFlush,
    input  logic [WIDTH-1:0] iOperandA,
    input  logic [WIDTH-1:0] iOperandB,
    output logic             oStall,
    output logic             oWriteEnable,
    output logic [WIDTH-1:0] oResult,
    output logic             oOverflow,
    output logic             oBusy
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [1:0]    state;
    logic [1:0]    nextState;
    logic          load;
    logic          step;
    logic          captureResult;
    logic          last;
    logic [PW-1:0] accNext;

    mul_shift_add_datapath #(
        .WIDTH(WIDTH)
    ) uDatapath (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (load),
        .step     (step),
        .operandA (iOperandA),
        .operandB (iOperandB),
        .accNext_c(accNext),
        .last_c   (last)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= MUL_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Stall and write strobe are combinational so decode sees them in the same cycle; reset masks them.
    always_comb begin
        nextState     = state;
        load          = 1'b0;
        step          = 1'b0;
        captureResult = 1'b0;
        oStall        = 1'b0;
        oWriteEnable  = 1'b0;
        if (!Reset) begin
            case (state)
                MUL_BUSY: begin
                    if (iFlush) begin
                        nextState = MUL_IDLE;
                    end else begin
                        step   = 1'b1;
                        oStall = 1'b1;
                        if (last) begin
                            nextState     = MUL_DONE;
                            captureResult = 1'b1;
                        end
                    end
                end
                MUL_DONE: begin
                    nextState    = MUL_IDLE;
                    oWriteEnable = !iFlush;
                end
                default: begin
                    // Unused encoding 2'd3 behaves as idle.
                    if (iStart && !iFlush) begin
                        load      = 1'b1;
                        oStall    = 1'b1;
                        nextState = MUL_BUSY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oResult   <= '0;
            oOverflow <= 1'b0;
        end else if (captureResult) begin
            oResult   <= accNext[WIDTH-1:0];
            oOverflow <= |accNext[PW-1:WIDTH];
        end
    end

    assign oBusy = state != MUL_IDLE;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: directed scenarios then randomized traffic.
module tb_alu_mul_sequencer;

    localparam int unsigned W = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         iStart = 1'b0;
    logic         iFlush = 1'b0;
    logic [W-1:0] iOperandA = '0;
    logic [W-1:0] iOperandB = '0;
    logic         oStall;
    logic         oWriteEnable;
    logic [W-1:0] oResult;
    logic         oOverflow;
    logic         oBusy;

    alu_mul_sequencer #(.WIDTH(W)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iStart      (iStart),
        .iFlush      (iFlush),
        .iOperandA   (iOperandA),
        .iOperandB   (iOperandB),
        .oStall      (oStall),
        .oWriteEnable(oWriteEnable),
        .oResult     (oResult),
        .oOverflow   (oOverflow),
        .oBusy       (oBusy)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t popped;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference: cycles remaining until the multiply is finished (0 = idle, 1 = write cycle).
    int           mLeft = 0;
    bit           mValid = 0;
    logic [W-1:0] mRes = '0;
    logic         mOvf = 1'b0;
    logic [W-1:0] pendRes = '0;
    logic         pendOvf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic fl,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        logic           expStall;
        @(negedge Clock);
        cyc++;
        Reset = rst; iStart = st; iFlush = fl; iOperandA = a; iOperandB = b;
        #1;
        expStall = 1'b0;
        if (mValid) begin
            check("busy", 32'(oBusy), 32'(mLeft != 0));
            check("result", 32'(oResult), 32'(mRes));
            check("overflow", 32'(oOverflow), 32'(mOvf));
        end
        if (rst) begin
            mLeft = 0; mRes = '0; mOvf = 1'b0;
            sb.delete();
            mValid = 1;
        end else if (mLeft == 0) begin
            if (st && !fl) begin
                prod = (2*W)'(a) * (2*W)'(b);
                pendRes = prod[W-1:0];
                pendOvf = |prod[2*W-1:W];
                sb.push_back('{res: pendRes, ovf: pendOvf, cyc: cyc + W + 1});
                mLeft = W + 1;
                expStall = 1'b1;
            end
        end else if (mLeft == 1) begin
            if (fl) sb.delete(sb.size() - 1);
            mLeft = 0;
        end else begin
            if (fl) begin
                sb.delete(sb.size() - 1);
                mLeft = 0;
            end else begin
                expStall = 1'b1;
                mLeft--;
                if (mLeft == 1) begin
                    mRes = pendRes;
                    mOvf = pendOvf;
                end
            end
        end
        if (mValid) check("stall", 32'(oStall), 32'(expStall));
    endtask

    // Monitor: every write strobe must match the oldest outstanding multiply, on its cycle.
    always @(negedge Clock) begin
        #2;
        if (oWriteEnable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_write cycle %0d got strobe expected none", cyc);
            end else begin
                popped = sb.pop_front();
                check("write_cycle", 32'(cyc), 32'(popped.cyc));
                check("write_result", 32'(oResult), 32'(popped.res));
                check("write_overflow", 32'(oOverflow), 32'(popped.ovf));
            end
        end else if (oWriteEnable !== 1'b0 && mValid) begin
            checks++; errors++;
            $display("FAIL write_x cycle %0d got %b expected 0/1", cyc, oWriteEnable);
        end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
            popped = sb.pop_front();
            checks++; errors++;
            $display("FAIL missed_write cycle %0d got no strobe expected at %0d", cyc, popped.cyc);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom(), $urandom());
    endtask

    task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b);
        step(1'b0, 1'b1, 1'b0, a, b);
        idle(W + 2);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0005);
        idle(2);

        mul(16'h0003, 16'h0005);
        mul(16'hFFFF, 16'hFFFF);
        mul(16'h0100, 16'h0100);
        mul(16'h1234, 16'h0000);

        // Flush mid-multiply, then a normal multiply.
        step(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0009);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 16'h0007, 16'h0009);
        idle(3);
        mul(16'h0003, 16'h0005);

        // Reset mid-busy with start held low.
        step(1'b0, 1'b1, 1'b0, 16'h00AA, 16'h0055);
        idle(7);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        idle(4);

        // Back-to-back with start held high through both stalls.
        step(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0003);
        for (int i = 0; i < 35; i++) step(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0005);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom % 4)
                0: ra = '0;
                1: ra = '1;
                default: ra = W'($urandom);
            endcase
            case ($urandom % 4)
                0: rb = '0;
                1: rb = '1;
                default: rb = W'($urandom);
            endcase
            step(1'b0 | ($urandom % 400 == 0), ($urandom % 3) != 0, ($urandom % 25) == 0, ra, rb);
        end
        idle(W + 4);
        check("pending_writes", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
